// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: number-guessing round sequencer (target pick, timer control, grading, win/lose).
// Optional GUESS_LIMIT_EN ends the round after MAX_ATTEMPTS wrong guesses.
module guess_round_ctrl #(
  parameter logic [9:0] LFSR_SEED    = 10'h2A5,
  parameter int         MAX_ATTEMPTS = 7
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       start,
  input  logic [1:0] Max_digit,
  input  logic       guess_valid,
  input  logic [9:0] guess,
  input  logic [6:0] timer_count,
  output logic       timer_restart_n,
  output logic       busy,
  output logic [1:0] hint,
  output logic       win,
  output logic       lose,
  output logic [6:0] score,
  output logic [3:0] attempts,
  output logic [9:0] target
);
  typedef enum logic [2:0] {IDLE, PICK, ARM, PLAY, WIN, LOSE} state_t;
  localparam logic [9:0] SEED = (LFSR_SEED == 10'd0) ? 10'd1 : LFSR_SEED;
`ifdef GUESS_LIMIT_EN
  localparam logic [3:0] MAX_A = 4'(MAX_ATTEMPTS);
`endif
  state_t     state_q, state_d;
  logic [9:0] lfsr_q, lfsr_d, target_q, target_d, limit, cand;
  logic [1:0] diff_q, diff_d, hint_q, hint_d;
  logic [6:0] score_q, score_d;
  logic [3:0] att_q, att_d, att_inc;
  logic       first_q, first_d, trn_q, busy_q, win_q, lose_q, eq;
  assign limit   = (diff_q == 2'd1) ? 10'd10 : (diff_q == 2'd2) ? 10'd100 : 10'd1000;
  assign cand    = lfsr_q - 10'd1;
  assign att_inc = (att_q == 4'd15) ? 4'd15 : att_q + 4'd1;
  assign eq      = guess == target_q;
  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    target_d = target_q;
    diff_d   = diff_q;
    hint_d   = hint_q;
    score_d  = score_q;
    att_d    = att_q;
    first_d  = 1'b0;
    case (state_q)
      IDLE, WIN, LOSE: if (start) begin
        diff_d  = (Max_digit == 2'd0) ? 2'd1 : Max_digit;
        hint_d  = 2'b00;
        score_d = 7'd0;
        att_d   = 4'd0;
        state_d = PICK;
      end
      PICK: if (cand < limit) begin
        target_d = cand;
        state_d  = ARM;
      end
      ARM: begin
        first_d = 1'b1;
        state_d = PLAY;
      end
      PLAY: begin
        if (guess_valid) begin
          att_d  = att_inc;
          hint_d = (guess < target_q) ? 2'b01 : eq ? 2'b11 : 2'b10;
          if (eq) begin
            score_d = timer_count;
            state_d = WIN;
          end
        end
        // the timer is still reloading during the first PLAY cycle
        if (state_d != WIN && timer_count == 7'd0 && !first_q) begin
          score_d = 7'd0;
          state_d = LOSE;
        end
`ifdef GUESS_LIMIT_EN
        if (guess_valid && !eq && att_inc == MAX_A) begin
          score_d = 7'd0;
          state_d = LOSE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      target_q <= 10'd0;
      diff_q   <= 2'd1;
      hint_q   <= 2'b00;
      score_q  <= 7'd0;
      att_q    <= 4'd0;
      first_q  <= 1'b0;
      trn_q    <= 1'b0;
      busy_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      target_q <= target_d;
      diff_q   <= diff_d;
      hint_q   <= hint_d;
      score_q  <= score_d;
      att_q    <= att_d;
      first_q  <= first_d;
      trn_q    <= state_d == PLAY;
      busy_q   <= state_d == PICK || state_d == ARM || state_d == PLAY;
      win_q    <= state_d == WIN;
      lose_q   <= state_d == LOSE;
    end
  end
  assign timer_restart_n = trn_q;
  assign busy            = busy_q;
  assign hint            = hint_q;
  assign win             = win_q;
  assign lose            = lose_q;
  assign score           = score_q;
  assign attempts        = att_q;
  assign target          = target_q;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb_guess_round_ctrl: directed self-checking bench for guess_round_ctrl with an independent LFSR model.
module tb_guess_round_ctrl;
  logic       clk = 1'b0, restart = 1'b1, start = 1'b0, guess_valid = 1'b0;
  logic [1:0] Max_digit = 2'd0;
  logic [9:0] guess = 10'd0;
  logic [6:0] timer_count = 7'd0;
  logic       timer_restart_n, busy, win, lose;
  logic [1:0] hint;
  logic [6:0] score;
  logic [3:0] attempts;
  logic [9:0] target;
  int         n_cmp = 0, n_err = 0, exp_att = 0;
  logic [9:0] m_lfsr, exp_t;

  guess_round_ctrl dut (
    .clk(clk), .restart(restart), .start(start), .Max_digit(Max_digit),
    .guess_valid(guess_valid), .guess(guess), .timer_count(timer_count),
    .timer_restart_n(timer_restart_n), .busy(busy), .hint, .win(win),
    .lose(lose), .score(score), .attempts(attempts), .target(target)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] step(input logic [9:0] v);
    return {v[8:0], v[9] ^ v[6]};
  endfunction

  always @(posedge clk or posedge restart)
    if (restart) m_lfsr <= 10'h2A5;
    else m_lfsr <= step(m_lfsr);

  task automatic check(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [1:0] md, input logic [6:0] tc, input string tag);
    int lim, k, cnt;
    logic [9:0] v;
    Max_digit = md;
    start = 1'b1;
    tick;
    start = 1'b0;
    Max_digit = ~md;
    timer_count = tc;
    lim = (md == 2'd2) ? 100 : (md == 2'd3) ? 1000 : 10;
    v = m_lfsr;
    k = 0;
    while (v - 10'd1 >= lim) begin
      v = step(v);
      k++;
    end
    exp_t = v - 10'd1;
    exp_att = 0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_hint_clr"}, hint, 0);
    check({tag, "_att_clr"}, attempts, 0);
    cnt = 0;
    while (!timer_restart_n && cnt < 2000) begin
      tick;
      cnt++;
    end
    check({tag, "_arm_latency"}, cnt, k + 2);
    check({tag, "_target"}, target, exp_t);
    check({tag, "_target_lim"}, int'(target) < lim, 1);
  endtask

  task automatic do_guess(input logic [9:0] g, input int exp_h, input string tag);
    guess = g;
    guess_valid = 1'b1;
    tick;
    guess_valid = 1'b0;
    exp_att = (exp_att < 15) ? exp_att + 1 : 15;
    check({tag, "_hint"}, hint, exp_h);
    check({tag, "_att"}, attempts, exp_att);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick;
    restart = 1'b0;
    repeat (5) tick;
    check("rst_trn", timer_restart_n, 0);
    check("rst_busy", busy, 0);
    check("rst_win", win, 0);
    check("rst_lose", lose, 0);
    check("rst_hint", hint, 0);
    check("rst_score", score, 0);
    check("rst_att", attempts, 0);
    check("rst_target", target, 0);

    start_round(2'd1, 7'd30, "t2");
    timer_count = 7'd25;
    if (exp_t > 0) do_guess(exp_t - 10'd1, 1, "t2_lo");
    timer_count = 7'd24;
    do_guess(exp_t + 10'd1, 2, "t2_hi");
    check("t2_win_early", win, 0);
    timer_count = 7'd23;
    do_guess(exp_t, 3, "t2_eq");
    check("t2_win", win, 1);
    check("t2_score", score, 23);
    check("t2_busy", busy, 0);
    check("t2_trn", timer_restart_n, 0);

    start_round(2'd2, 7'd60, "t3");
    timer_count = 7'd59;
    tick;
    check("t3_lose_early", lose, 0);
    check("t3_trn_play", timer_restart_n, 1);
    timer_count = 7'd0;
    tick;
    check("t3_lose", lose, 1);
    check("t3_win", win, 0);
    check("t3_score", score, 0);
    check("t3_trn", timer_restart_n, 0);
    check("t3_busy", busy, 0);

    start_round(2'd3, 7'd0, "t4");
    tick;
    check("t4_first_busy", busy, 1);
    check("t4_first_lose", lose, 0);
    do_guess(exp_t, 3, "t4_eq");
    check("t4_win", win, 1);
    check("t4_score", score, 0);
    check("t4_lose", lose, 0);

    start_round(2'd0, 7'd40, "t5");
    start = 1'b1;
    tick;
    start = 1'b0;
    check("t5_start_busy", busy, 1);
    check("t5_start_trn", timer_restart_n, 1);
    for (int i = 0; i < 7; i++) begin
      if (i == 6) check("t6_lose_pre", lose, 0);
      do_guess(exp_t + 10'd1, 2, $sformatf("t6_g%0d", i + 1));
    end
`ifdef GUESS_LIMIT_EN
    check("t6_lose", lose, 1);
    check("t6_busy", busy, 0);
    check("t6_score", score, 0);
`else
    check("t6_lose", lose, 0);
    check("t6_busy", busy, 1);
`endif

    restart = 1'b1;
    #2;
    check("t7_async_busy", busy, 0);
    check("t7_async_att", attempts, 0);
    check("t7_async_trn", timer_restart_n, 0);
    tick;
    restart = 1'b0;
    check("t7_target", target, 0);
    check("t7_hint", hint, 0);
    check("t7_lose", lose, 0);
    tick;
    start_round(2'd1, 7'd30, "t7");
    do_guess(exp_t, 3, "t7_eq");
    check("t7_score", score, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
